// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl
//   Reader-side companion to the processor register file. It walks a
//   contiguous, wrap-around range of register indices through one read port.
//   Each word is streamed out on a valid/ready interface and tagged with its
//   index. The debug/trace path uses it to dump architectural state while
//   the write port keeps running.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 begin a dump (only looked at while idle)
//   abort                 synchronous cancel of a dump in progress
//   first_reg, last_reg   inclusive index range, captured with start
//   rf_ra / rf_rd         register-file read address / combinational data
//   out_valid/out_ready   output handshake
//   out_data, out_idx     captured word and its register index
//   out_last              marks the final word of the dump
//   busy                  high whenever a dump is in progress
//   done                  one-cycle pulse when a dump finishes or is aborted
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// READ  | rf_ra = ptr; capture rf_rd into the output register
// SEND  | word presented on the output, waiting for the handshake
// DONE  | one-cycle done pulse, then back to IDLE

module reg_dump_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d   = first_reg;
                    last_d  = last_reg;
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    // rf_rd is sampled as presented this cycle, so a write
                    // landing on the same edge is not seen in this word.
                    out_data_d  = rf_rd;
                    out_idx_d   = ptr_q;
                    out_last_d  = (ptr_q == last_q);
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_DONE;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (ptr_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // Natural modulo-2**ADDR_W wrap takes the top index to 0.
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rf_ra     = ptr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl
//   Self-checking bench for reg_dump_ctrl. The bench owns a 16-entry
//   register file with one write port. Each dump's expected word list is
//   built from the index range and a snapshot of that file. Every cycle of
//   the output stream is compared against the list.

module tb_reg_dump_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_reg;
    logic [AW-1:0] last_reg;
    logic [AW-1:0] rf_ra;
    logic [DW-1:0] rf_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [16];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int            n_total = 0;
    int            n_bad   = 0;
    logic [DW-1:0] last_word;

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
    assign rf_rd = rf[rf_ra];

    reg_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rf_ra     (rf_ra),
        .rf_rd     (rf_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; the write is taken on the next rising edge.
    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // One complete dump.
    //   rand_rdy : randomise out_ready
    //   stall_k  : word number held off for stall_n cycles (-1 = none)
    //   abort_k  : word number aborted while presented (>= count = none)
    //   noise    : toggle start/first_reg while busy (must be ignored)
    //   coll     : write 0xDEAD to rf[f] on the edge that reads it
    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input bit rand_rdy, input int stall_k, input int stall_n,
                            input int abort_k, input bit noise, input bit coll);
        logic [DW-1:0] exp_d[$];
        logic [AW-1:0] exp_i[$];
        logic [AW-1:0] diff;
        logic [AW-1:0] ix;
        logic [DW-1:0] pd;
        logic [AW-1:0] pi;
        int  cnt, k, cyc, done_cnt, first_v, stall_left, last_hs, abort_cyc;
        bit  prev_pend, aborted, fin;

        diff = l - f;
        cnt  = int'(diff) + 1;
        for (int i = 0; i < cnt; i++) begin
            ix = f + AW'(i);
            exp_i.push_back(ix);
            exp_d.push_back(rf[ix]);
        end

        @(posedge clk); #1;
        start     = 1'b1;
        first_reg = f;
        last_reg  = l;
        out_ready = 1'b0;
        abort     = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_in_read", out_valid, 0);

        k = 0; cyc = 0; done_cnt = 0; first_v = -1; stall_left = stall_n;
        last_hs = -10; abort_cyc = -10; prev_pend = 0; aborted = 0; fin = 0;
        while (!fin && cyc < 200) begin
            abort = 1'b0;
            wr_en = (coll && cyc == 0);
            wr_addr = f;
            wr_data = 32'hDEAD;
            if (noise && done_cnt == 0) begin
                start     = 1'($urandom_range(0, 1));
                first_reg = AW'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            if (out_valid && k == abort_k && !aborted) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                aborted   = 1;
                abort_cyc = cyc;
            end else if (out_valid && k == stall_k && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            end

            @(negedge clk);
            if (aborted && cyc == abort_cyc + 1) begin
                chk("abort_valid_drop", out_valid, 0);
                chk("abort_done", done, 1);
            end
            if (out_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("first_valid_latency", cyc, 1);
                end
                if (prev_pend) begin
                    chk("hold_data", out_data, pd);
                    chk("hold_idx", out_idx, pi);
                end
                if (k < cnt) begin
                    chk("idx", out_idx, exp_i[k]);
                    chk("data", out_data, exp_d[k]);
                    chk("last", out_last, (k == cnt - 1));
                end else begin
                    chk("extra_word", k, cnt - 1);
                end
                pd = out_data;
                pi = out_idx;
                prev_pend = !out_ready && !abort;
                if (out_ready) begin
                    last_word = out_data;
                    if (k == cnt - 1) last_hs = cyc;
                    k++;
                end
            end else begin
                if (prev_pend) chk("valid_held", out_valid, 1);
                prev_pend = 0;
            end
            if (done) begin
                done_cnt++;
                if (!aborted) chk("done_latency", cyc, last_hs + 1);
            end else if (done_cnt > 0) begin
                chk("idle_after_done", busy, 0);
                fin = 1;
            end

            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        chk("dump_finished", fin, 1);
        chk("done_once", done_cnt, 1);
        if (aborted) chk("abort_word_count", k, abort_k);
        else         chk("word_count", k, cnt);
    endtask

    initial begin
        int w, dseen, nrand;
        logic [AW-1:0] rf_f, rf_l;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_reg = '0; last_reg = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        last_word = '0;
        #12;
        chk("rst_rf_ra", rf_ra, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) rf_write(AW'(i), $urandom);
        rf_write(4'd2, 32'h11);
        rf_write(4'd3, 32'h22);
        rf_write(4'd4, 32'h33);
        rf_write(4'd5, 32'h44);
        rf_write(4'd15, 32'h0000_0100);

        // Asynchronous reset while a word is waiting in SEND.
        start = 1'b1; first_reg = 4'd2; last_reg = 4'd5; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin @(posedge clk); #1; w++; end
        chk("rst_reach_send", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_idx", out_idx, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_rf_ra", rf_ra, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        dseen = 0;
        repeat (4) begin @(negedge clk); if (done) dseen++; end
        chk("midrst_no_done", dseen, 0);
        chk("midrst_idle", busy, 0);

        // Basic range and wrap through the PC index.
        run_dump(4'd2, 4'd5, 0, -1, 0, 99, 0, 0);
        chk("basic_last_word", last_word, 32'h44);
        run_dump(4'd14, 4'd1, 0, -1, 0, 99, 0, 0);
        run_dump(4'd15, 4'd15, 0, -1, 0, 99, 0, 0);
        chk("pc_word", last_word, 32'h100);

        // Backpressure on the second word.
        run_dump(4'd2, 4'd5, 0, 1, 5, 99, 0, 0);

        // Write collision on the read edge.
        @(posedge clk); #1;
        rf_write(4'd3, 32'hBEEF);
        run_dump(4'd3, 4'd3, 0, -1, 0, 99, 0, 1);
        chk("coll_old_value", last_word, 32'hBEEF);
        run_dump(4'd3, 4'd3, 0, -1, 0, 99, 0, 0);
        chk("coll_new_value", last_word, 32'hDEAD);

        // Abort during the second word, then a single-word dump.
        run_dump(4'd4, 4'd9, 0, -1, 0, 1, 0, 0);
        run_dump(4'd7, 4'd7, 0, -1, 0, 99, 0, 0);

        // Randomised dumps.
        nrand = 25;
        for (int t = 0; t < nrand; t++) begin
            @(posedge clk); #1;
            rf_write(AW'($urandom_range(0, 15)), $urandom);
            rf_f = AW'($urandom_range(0, 15));
            rf_l = AW'($urandom_range(0, 15));
            run_dump(rf_f, rf_l, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 24)), 1, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
